// File: rtl/factorial_accel_if.sv
// Register-bus connection between a host and the factorial accelerator.
// A transfer occurs on every rising clk edge where s_sel is high; there is no
// wait state, and during a read (s_wr=0) s_dout is valid combinationally.
interface factorial_accel_if #(parameter int DW = 64);
  logic          s_sel;
  logic          s_wr;
  logic [15:0]   s_addr;
  logic [DW-1:0] s_din;
  logic [DW-1:0] s_dout;

  modport master (output s_sel, s_wr, s_addr, s_din, input s_dout);
  modport slave  (input s_sel, s_wr, s_addr, s_din, output s_dout);
endinterface

// File: rtl/factorial_accel.sv
// Memory-mapped factorial accelerator: OPERAND! computed by repeated radix-2
// shift-add multiplies into a 2*DW-bit result, with overflow detection.
module factorial_accel #(
  parameter int         DW        = 64,
  parameter logic [7:0] BASE_ADDR = 8'h70
) (
  input  logic             clk,
  input  logic             reset_n,
  factorial_accel_if.slave bus,
  output logic             interrupt,
  output logic [2:0]       fsm_state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    STEP = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t          state;
  logic            done, busy, ovf, intr_en;
  logic [DW-1:0]   operand, res_h, res_l, cycles, k, mplier;
  logic [3*DW-1:0] mcand, prod;
  logic [CW-1:0]   bit_cnt;

  logic       hit, wr_en, start_req, clear_req, op_wr, ien_wr, can_start;
  logic [4:0] idx;
  logic       unused_bits;

  assign hit       = bus.s_addr[15:8] == BASE_ADDR;
  assign idx       = bus.s_addr[7:3];
  assign wr_en     = bus.s_sel & bus.s_wr & hit;
  assign start_req = wr_en && (idx == 5'd0) && bus.s_din[0];
  assign clear_req = wr_en && (idx == 5'd1) && bus.s_din[0];
  assign ien_wr    = wr_en && (idx == 5'd3);
  assign op_wr     = wr_en && (idx == 5'd4);
  assign can_start = (state == IDLE) || (state == DONE);
  assign unused_bits = ^bus.s_addr[2:0];

  assign interrupt = done & intr_en;
  assign fsm_state = state;

  always_comb begin
    bus.s_dout = '0;
    if (bus.s_sel && !bus.s_wr && hit) begin
      case (idx)
        5'd2:    bus.s_dout = DW'({ovf, busy, done});
        5'd3:    bus.s_dout = DW'(intr_en);
        5'd4:    bus.s_dout = operand;
        5'd5:    bus.s_dout = res_h;
        5'd6:    bus.s_dout = res_l;
        5'd7:    bus.s_dout = cycles;
        default: bus.s_dout = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      done    <= 1'b0;
      busy    <= 1'b0;
      ovf     <= 1'b0;
      intr_en <= 1'b0;
      operand <= '0;
      res_h   <= '0;
      res_l   <= DW'(1);
      cycles  <= '0;
      k       <= '0;
      mplier  <= '0;
      mcand   <= '0;
      prod    <= '0;
      bit_cnt <= '0;
    end else begin
      if (ien_wr) intr_en <= bus.s_din[0];
      if (op_wr && can_start) operand <= bus.s_din;

      // CLEAR outranks everything, including a START in the same cycle.
      if (clear_req) begin
        state  <= IDLE;
        done   <= 1'b0;
        busy   <= 1'b0;
        ovf    <= 1'b0;
        res_h  <= '0;
        res_l  <= DW'(1);
        cycles <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start_req) begin
              state <= LOAD;
              busy  <= 1'b1;
              done  <= 1'b0;
              ovf   <= 1'b0;
            end
          end
          LOAD: begin
            cycles <= DW'(1);
            k      <= DW'(2);
            if (operand < DW'(2)) begin
              res_h <= '0;
              res_l <= DW'(1);
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              mcand   <= (3*DW)'(1);
              mplier  <= DW'(2);
              prod    <= '0;
              bit_cnt <= '0;
              state   <= MUL;
            end
          end
          MUL: begin
            // One multiplier bit per cycle; mcand carries acc shifted to the bit's weight.
            cycles  <= cycles + 1'b1;
            if (mplier[0]) prod <= prod + mcand;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == CW'(DW-1)) state <= STEP;
          end
          STEP: begin
            cycles <= cycles + 1'b1;
            if (|prod[3*DW-1:2*DW]) begin
              ovf   <= 1'b1;
              res_h <= prod[2*DW-1:DW];
              res_l <= prod[DW-1:0];
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else if (k == operand) begin
              res_h <= prod[2*DW-1:DW];
              res_l <= prod[DW-1:0];
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              k       <= k + 1'b1;
              mplier  <= k + 1'b1;
              mcand   <= {{DW{1'b0}}, prod[2*DW-1:0]};
              prod    <= '0;
              bit_cnt <= '0;
              state   <= MUL;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
